// File: rtl/spi_tx_scheduler.sv
// Queues words in a small FIFO and feeds them one at a time to an SPI master
// over its active-low start / busy handshake, returning the slave's reply words.
module spi_tx_scheduler #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                       CLOCK_50,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  output logic                       spi_start_n,
  output logic [WIDTH-1:0]           spi_data_in,
  input  logic                       spi_busy,
  input  logic [WIDTH-1:0]           spi_data_out,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       err_timeout,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              start_n_q, start_n_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic push;
  logic pop;

  // Saturating increment: the timer parks at TIMEOUT instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    if (v == TMAX) return v;
    return v + TW'(1);
  endfunction

  assign wr_ready = (count_q != FULL);
  assign push     = wr_valid && wr_ready;

  // Control FSM; the head word is only popped once its transfer finishes or is dropped.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    start_n_d   = start_n_q;
    data_in_d   = data_in_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_n_d = 1'b1;
        if (count_q != '0) begin
          data_in_d = mem_q[rd_ptr_q];
          start_n_d = 1'b0;
          timer_d   = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (spi_busy) begin
          // Drop start on the first busy so the master cannot relaunch the same word.
          start_n_d = 1'b1;
          state_d   = S_WAIT;
        end else if (timer_q == TMAX) begin
          start_n_d = 1'b1;
          err_d     = 1'b1;
          pop       = 1'b1;
          state_d   = S_IDLE;
        end else begin
          start_n_d = 1'b0;
          timer_d   = sat_inc(timer_q);
        end
      end
      S_WAIT: begin
        start_n_d = 1'b1;
        if (!spi_busy) begin
          rsp_data_d  = spi_data_out;
          rsp_valid_d = 1'b1;
          pop         = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        start_n_d = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      start_n_q   <= 1'b1;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      start_n_q   <= start_n_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Storage is not reset; an empty count makes stale entries unreachable.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign spi_start_n = start_n_q;
  assign spi_data_in = data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err_timeout = err_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a simple SPI master model attached.
module tb_spi_tx_scheduler;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 15;

  logic                clk;
  logic                rst_n;
  logic                mst_rst_n;
  logic                wr_valid;
  logic [W-1:0]        wr_data;
  logic                wr_ready;
  logic                spi_start_n;
  logic [W-1:0]        spi_data_in;
  logic                spi_busy;
  logic [W-1:0]        spi_data_out;
  logic                rsp_valid;
  logic [W-1:0]        rsp_data;
  logic                err_timeout;
  logic [$clog2(D):0]  fifo_count;

  int tests;
  int fails;

  always begin
    clk = 1'b0; #5;
    clk = 1'b1; #5;
  end

  spi_tx_scheduler #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .CLOCK_50     (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .spi_start_n  (spi_start_n),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_data_out (spi_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err_timeout  (err_timeout),
    .fifo_count   (fifo_count)
  );

  // Master model: samples start one edge, raises busy the next, holds busy busy_len cycles.
  logic         mst_en;
  int           busy_len;
  logic [W-1:0] key;
  logic         mst_arm;
  int           mst_cnt;
  logic [W-1:0] mst_word;
  int           xfers;

  always @(posedge clk) begin
    if (!mst_rst_n) begin
      mst_arm      <= 1'b0;
      spi_busy     <= 1'b0;
      spi_data_out <= '0;
      mst_cnt      <= 0;
      mst_word     <= '0;
      xfers        <= 0;
    end else if (mst_arm) begin
      mst_arm  <= 1'b0;
      spi_busy <= 1'b1;
      mst_cnt  <= busy_len;
    end else if (spi_busy) begin
      if (mst_cnt <= 1) begin
        spi_busy     <= 1'b0;
        spi_data_out <= mst_word ^ key;
      end else begin
        mst_cnt <= mst_cnt - 1;
      end
    end else if (mst_en && !spi_start_n) begin
      mst_arm  <= 1'b1;
      mst_word <= spi_data_in;
      xfers    <= xfers + 1;
    end
  end

  // Response / timeout / duplicate-start monitor
  int           rsp_n;
  int           to_n;
  int           viol;
  logic         busy_d1;
  logic [W-1:0] rsp_log [0:255];

  always @(negedge clk) begin
    if (!mst_rst_n) begin
      rsp_n   <= 0;
      to_n    <= 0;
      viol    <= 0;
      busy_d1 <= 1'b0;
    end else begin
      busy_d1 <= spi_busy;
      if (spi_busy && busy_d1 && !spi_start_n) viol <= viol + 1;
      if (rsp_valid) begin
        rsp_log[rsp_n[7:0]] <= rsp_data;
        rsp_n <= rsp_n + 1;
      end
      if (err_timeout) to_n <= to_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (rsp_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rsp_n, target);
  endtask

  task automatic wait_waitdone(input int budget, input string tag);
    int k;
    k = 0;
    while (!(spi_busy && spi_start_n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'({spi_busy, spi_start_n}), 32'h3);
  endtask

  initial begin
    int base;
    int tbase;
    int xb;
    int vb;
    int k;
    logic [W-1:0] e;

    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    mst_rst_n = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    mst_en    = 1'b0;
    busy_len  = 4;
    key       = '0;
    repeat (3) @(negedge clk);

    check("rst_start_n", 32'(spi_start_n), 1);
    check("rst_data_in", 32'(spi_data_in), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    rst_n     = 1'b1;
    mst_rst_n = 1'b1;
    @(negedge clk);

    // Single word: DEAD out, BEEF back
    key      = 16'hDEAD ^ 16'hBEEF;
    busy_len = 6;
    mst_en   = 1'b1;
    base     = rsp_n;
    push_one(16'hDEAD);
    check("t1_count1", 32'(fifo_count), 1);
    check("t1_start_idle", 32'(spi_start_n), 1);
    @(negedge clk);
    check("t1_start_low", 32'(spi_start_n), 0);
    check("t1_data_req", 32'(spi_data_in), 32'hDEAD);
    repeat (3) @(negedge clk);
    check("t1_start_rel", 32'(spi_start_n), 1);
    check("t1_busy", 32'(spi_busy), 1);
    check("t1_data_wait", 32'(spi_data_in), 32'hDEAD);
    repeat (6) @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_data", 32'(rsp_data), 32'hBEEF);
    check("t1_count0", 32'(fifo_count), 0);
    @(negedge clk);
    check("t1_rsp_pulse", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    check("t1_rsp_n", rsp_n - base, 1);

    // Fill and overflow with the master stalled
    mst_en   = 1'b0;
    key      = '0;
    busy_len = 3;
    base     = rsp_n;
    xb       = xfers;
    tbase    = to_n;
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) check("t2_ready_3", 32'(wr_ready), 1);
      if (i == 5) check("t2_ready_full", 32'(wr_ready), 0);
      wr_valid = 1'b1;
      wr_data  = 16'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("t2_count4", 32'(fifo_count), 4);
    check("t2_ready_after", 32'(wr_ready), 0);
    mst_en = 1'b1;
    wait_rsp(base + 4, 200, "t2_rsp_wait");
    repeat (10) @(negedge clk);
    check("t2_rsp_n", rsp_n - base, 4);
    for (int i = 0; i < 4; i++) check("t2_order", 32'(rsp_log[base + i]), 32'(i + 1));
    check("t2_count0", 32'(fifo_count), 0);
    check("t2_xfers", xfers - xb, 4);
    check("t2_no_to", to_n - tbase, 0);

    // Push on the same edge as a completion pop, across pointer wrap
    key  = 16'h00FF;
    base = rsp_n;
    push_one(16'hA000);
    for (int i = 1; i <= 10; i++) begin
      wait_waitdone(50, "t3_waitdone");
      k = 0;
      while (spi_busy && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("t3_pre_count", 32'(fifo_count), 1);
      wr_valid = 1'b1;
      wr_data  = 16'hA000 + 16'(i);
      @(negedge clk);
      wr_valid = 1'b0;
      check("t3_count_same", 32'(fifo_count), 1);
      check("t3_rsp_strobe", 32'(rsp_valid), 1);
    end
    wait_rsp(base + 11, 100, "t3_rsp_wait");
    @(negedge clk);
    for (int i = 0; i <= 10; i++) begin
      e = (16'hA000 + 16'(i)) ^ 16'h00FF;
      check("t3_order", 32'(rsp_log[base + i]), 32'(e));
    end
    check("t3_count0", 32'(fifo_count), 0);

    // Timeout with busy never rising
    mst_en = 1'b0;
    base   = rsp_n;
    tbase  = to_n;
    xb     = xfers;
    push_one(16'h0BAD);
    repeat (16) @(negedge clk);
    check("t4_err_early", 32'(err_timeout), 0);
    check("t4_start_held", 32'(spi_start_n), 0);
    check("t4_count_held", 32'(fifo_count), 1);
    @(negedge clk);
    check("t4_err_pulse", 32'(err_timeout), 1);
    check("t4_start_rel", 32'(spi_start_n), 1);
    check("t4_count0", 32'(fifo_count), 0);
    check("t4_no_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    check("t4_err_once", 32'(err_timeout), 0);
    repeat (3) @(negedge clk);
    check("t4_to_n", to_n - tbase, 1);
    check("t4_rsp_n", rsp_n - base, 0);
    check("t4_xfers", xfers - xb, 0);

    // Long busy: start must stay released, one transfer per word
    mst_en   = 1'b1;
    busy_len = 40;
    key      = 16'h1234;
    base     = rsp_n;
    xb       = xfers;
    vb       = viol;
    push_one(16'h5555);
    push_one(16'h6666);
    wait_rsp(base + 2, 300, "t5_rsp_wait");
    repeat (6) @(negedge clk);
    check("t5_no_dup_start", viol - vb, 0);
    check("t5_xfers", xfers - xb, 2);
    check("t5_rsp_n", rsp_n - base, 2);
    check("t5_rsp0", 32'(rsp_log[base]), 32'(16'h5555 ^ 16'h1234));
    check("t5_rsp1", 32'(rsp_log[base + 1]), 32'(16'h6666 ^ 16'h1234));

    // Reset in WAIT_DONE with three words queued
    busy_len = 30;
    key      = '0;
    base     = rsp_n;
    xb       = xfers;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 16'h7100 + 16'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_waitdone(50, "t6_waitdone");
    check("t6_count_pre", 32'(fifo_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_start_n", 32'(spi_start_n), 1);
    check("t6_count", 32'(fifo_count), 0);
    check("t6_wr_ready", 32'(wr_ready), 1);
    check("t6_data_in", 32'(spi_data_in), 0);
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_rsp_data", 32'(rsp_data), 0);
    check("t6_err", 32'(err_timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("t6_no_rsp", rsp_n - base, 0);
    check("t6_count_after", 32'(fifo_count), 0);
    check("t6_start_after", 32'(spi_start_n), 1);
    check("t6_xfers", xfers - xb, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
